// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard controller. It merges per-stage stall requests
// into a thermometer freeze mask and holds the front end for multi-cycle
// execute ops with a bounded counter. On a flush request it issues a
// one-cycle clear pulse and a redirect PC.
module pipe_ctrl #(
   parameter int STAGES      = 6,
   parameter int NSRC        = 4,
   parameter int MC_STAGE    = 3,
   parameter int MC_CYCLES   = 32,
   parameter int FLUSH_STAGE = 4,
   parameter int AW          = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NSRC-1:0]   stall_req,
   input  logic              mc_start,
   input  logic              mc_done,
   input  logic              flush_req,
   input  logic [AW-1:0]     flush_pc,
   output logic [STAGES-1:0] stall,
   output logic [STAGES-1:0] flush,
   output logic [AW-1:0]     new_pc,
   output logic              busy
);

   localparam int CW = $clog2(MC_CYCLES);
   localparam logic [CW-1:0]     CNT_LOAD   = CW'(MC_CYCLES - 1);
   localparam logic [CW-1:0]     CNT_LAST   = CW'(1);
   localparam logic [STAGES-1:0] MC_MASK    = STAGES'((1 << (MC_STAGE + 1)) - 1);
   localparam logic [STAGES-1:0] FLUSH_MASK = STAGES'((1 << FLUSH_STAGE) - 1);

   typedef enum logic [1:0] {IDLE, MC_WAIT, FLUSH} state_t;

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [STAGES-1:0] src_mask;
   logic              mc_act;

   // Thermometer OR of the source masks. While a flush is requested, only
   // sources deeper than the flushing stage keep their freeze.
   always_comb begin
      src_mask = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (stall_req[i] && (!flush_req || (i + 2) > FLUSH_STAGE))
            src_mask = src_mask | STAGES'((1 << (i + 3)) - 1);
      end
   end

   // The MC hold covers the start cycle plus every MC_WAIT cycle not yet done.
   // A FLUSH cycle that accepts mc_start only arms the counter and does not
   // freeze, because the stall in FLUSH comes from stall_req alone.
   always_comb begin
      mc_act = !flush_req &&
               ((state == IDLE && mc_start) || (state == MC_WAIT && !mc_done));
      stall  = rst ? (src_mask | (mc_act ? MC_MASK : '0)) : '0;
   end

   // State, hold counter and registered flush/redirect/busy outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         cnt    <= '0;
         flush  <= '0;
         new_pc <= '0;
         busy   <= 1'b0;
      end else begin
         flush <= '0;
         if (flush_req) begin
            state  <= FLUSH;
            cnt    <= '0;
            flush  <= FLUSH_MASK;
            new_pc <= flush_pc;
            busy   <= 1'b1;
         end else begin
            case (state)
               IDLE, FLUSH: begin
                  if (mc_start) begin
                     state <= MC_WAIT;
                     cnt   <= CNT_LOAD;
                     busy  <= 1'b1;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
               MC_WAIT: begin
                  // mc_start here is a protocol violation and is ignored.
                  if (mc_done || cnt == CNT_LAST) begin
                     state <= IDLE;
                     cnt   <= '0;
                     busy  <= 1'b0;
                  end else begin
                     cnt <= cnt - CNT_LAST;
                  end
               end
               default: begin
                  state <= IDLE;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline hazard controller for the CPU core. It merges per-stage stall requests into a thermometer stall vector, sequences multi-cycle execute operations (divider, multiplier) with a bounded hold counter, and issues one-cycle flush pulses with a redirect PC on branch or exception. It sits beside the pipeline registers and drives their stall/flush inputs and the PC-load path.

## Interface
- STAGES, 6, width of `stall`/`flush`; bit 0 = PC, bit k = pipeline register after stage k
- NSRC, 4, number of stall request sources; source i sits at stage i+2; STAGES >= NSRC+2
- MC_STAGE, 3, stage issuing multi-cycle ops (EX)
- MC_CYCLES, 32, maximum stall cycles per multi-cycle op; >= 2
- FLUSH_STAGE, 4, stage issuing flush requests (MEM); 1 <= FLUSH_STAGE < STAGES
- AW, 32, PC width

- clk  in  1  core clock
- rst  in  1  reset: one clock; reset is asynchronous and active-low
- stall_req  in  NSRC  per-source stall request, level, sampled combinationally
- mc_start  in  1  one-cycle pulse: multi-cycle op begins in MC_STAGE
- mc_done  in  1  multi-cycle op finished early
- flush_req  in  1  flush younger stages and redirect
- flush_pc  in  AW  redirect target, qualified by flush_req
- stall  out  STAGES  freeze mask, combinational
- flush  out  STAGES  clear mask, registered
- new_pc  out  AW  redirect PC, registered, valid when flush[0]=1
- busy  out  1  state != IDLE

## Operation
- States: IDLE, MC_WAIT, FLUSH. Reset (rst=0) forces IDLE, counter 0, flush=0, new_pc=0, stall=0, busy=0, immediately and asynchronously.
- Source mask: stall_req[i]=1 sets stall bits [i+2:0]. The final stall value is the OR of all active masks plus the MC mask, so the deepest requester wins.
- MC mask = bits [MC_STAGE:0]. It is active in IDLE when mc_start=1 and flush_req=0, and in MC_WAIT when mc_done=0.
- IDLE + mc_start (no flush_req) -> MC_WAIT, counter loaded with MC_CYCLES-1.
- MC_WAIT:
  - The counter decrements each cycle.
  - Return to IDLE when mc_done=1; the mask drops that same cycle.
  - Otherwise return to IDLE after the cycle in which counter==1.
  - Total stall is exactly MC_CYCLES cycles including the start cycle.
- flush_req=1 in any state:
  - Next state is FLUSH.
  - Registered next cycle: flush = bits [FLUSH_STAGE-1:0] set, new_pc = flush_pc.
  - Any MC_WAIT is aborted and the counter is cleared.
- In the cycle flush_req=1, stall keeps only masks from sources at stages > FLUSH_STAGE. Lower-source and MC masks are suppressed.
- FLUSH (one cycle):
  - flush and new_pc hold the latched values.
  - stall is computed from stall_req only; the MC mask is inactive.
  - Next state: FLUSH again if flush_req=1 (relatch flush_pc), IDLE otherwise (if mc_start=1 that cycle, it is honoured as in IDLE).
- In every state other than FLUSH, flush=0. new_pc holds its last value.
- Simultaneous flush_req and mc_start: flush wins, mc_start is dropped, and no MC stall occurs.
- mc_start during MC_WAIT is ignored (protocol violation, no restart).

## Timing
- stall: zero-cycle combinational path from stall_req, mc_start, mc_done and flush_req.
- flush/new_pc: one-cycle latency from flush_req; one-cycle pulse per accepted request. Back-to-back requests give consecutive pulses.
- busy: registered. High from the cycle after mc_start until the IDLE return, and during FLUSH.
- Counter width is clog2(MC_CYCLES). No wrap: it saturates at 0 in IDLE.
- Reset deassertion is synchronised externally. The first active edge after rst=1 sees IDLE.

## Test plan
- Source masks (defaults): stall_req=4'b0001 -> stall=6'b000111. 4'b0101 -> 6'b011111. 4'b1000 -> 6'b111111. 0 -> 0, all same cycle.
- MC hold: MC_CYCLES=4, 1-cycle mc_start, mc_done=0 -> stall=6'b001111 for exactly 4 consecutive cycles. busy=1 for cycles 2-4. IDLE afterwards.
- MC early done: mc_start, then mc_done=1 on the 2nd MC_WAIT cycle -> stall=6'b001111 for 2 cycles, 0 in the mc_done cycle. busy low next cycle.
- Flush abort: in MC_WAIT, flush_req=1 with flush_pc=32'h0000_0100 -> stall=0 that cycle. Next cycle flush=6'b001111, new_pc=32'h100, stall=0. Following cycle flush=0, state IDLE.
- Flush vs deep stall: stall_req=4'b1000 with flush_req=1 -> stall=6'b111111 held. flush=6'b001111 next cycle.
- Collision and reset: flush_req with mc_start -> no MC stall cycles. Assert rst=0 mid-MC_WAIT -> stall, flush, new_pc and busy are 0 before the next clk edge.
